// File: rtl/dual_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// dual_fetch_queue_if
//
// Bundles the fetch/issue signals of the dual-issue fetch queue.
//   master : the fetch queue itself (drives PC1, issue slots, count)
//   slave  : the environment (instruction cache + decode + branch resolution)
//
// Signals:
//   PC1            fetch address to the instruction cache
//   IC1, IC2       instructions at PC1 and PC1+4 (combinational cache reply)
//   fetch_stall    hold fetch: no enqueue, no PC advance
//   redirect_valid flush queue and restart fetch at redirect_pc
//   redirect_pc    restart address (low two bits ignored)
//   issue_valid1/2 oldest / second-oldest slot valid
//   issue_instr1/2 slot instructions
//   issue_pc1/2    slot PCs
//   issue_take     entries decode consumes this cycle (3 behaves as 2)
//   count          occupied entries
// -----------------------------------------------------------------------------
interface dual_fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [63:0]      PC1;
    logic [31:0]      IC1;
    logic [31:0]      IC2;
    logic             fetch_stall;
    logic             redirect_valid;
    logic [63:0]      redirect_pc;
    logic             issue_valid1;
    logic             issue_valid2;
    logic [31:0]      issue_instr1;
    logic [31:0]      issue_instr2;
    logic [63:0]      issue_pc1;
    logic [63:0]      issue_pc2;
    logic [1:0]       issue_take;
    logic [CNT_W-1:0] count;

    modport master (
        output PC1,
        input  IC1, IC2,
        input  fetch_stall, redirect_valid, redirect_pc,
        output issue_valid1, issue_valid2,
        output issue_instr1, issue_instr2,
        output issue_pc1, issue_pc2,
        input  issue_take,
        output count
    );

    modport slave (
        input  PC1,
        output IC1, IC2,
        output fetch_stall, redirect_valid, redirect_pc,
        input  issue_valid1, issue_valid2,
        input  issue_instr1, issue_instr2,
        input  issue_pc1, issue_pc2,
        output issue_take,
        input  count
    );
endinterface

// File: rtl/dual_fetch_queue.sv
// -----------------------------------------------------------------------------
// dual_fetch_queue
//
// Fetch stage and instruction buffer of the dual-issue LEGv8 core. Generates
// the fetch PC, enqueues the two instructions the cache returns per cycle into
// a circular buffer, and presents the two oldest entries to decode. A redirect
// flushes the buffer and restarts fetch at the redirect target.
//
// Parameters:
//   DEPTH     queue entries (power of two, >= 4)
//   RESET_PC  fetch address after reset
//
// Ports:
//   CLOCK     rising-edge clock
//   RESET     asynchronous active-low reset
//   bus       dual_fetch_queue_if.master (fetch, redirect and issue signals)
// -----------------------------------------------------------------------------
module dual_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    dual_fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Control state
    logic [63:0]      r_pc;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;

    // Entry storage: {instr, pc}
    logic [31:0]      r_instr_mem [DEPTH];
    logic [63:0]      r_pc_mem    [DEPTH];

    logic [CNT_W-1:0] w_free;
    logic             w_enq;
    logic [1:0]       w_take_cap;
    logic [CNT_W-1:0] w_take_ext;
    logic [CNT_W-1:0] w_eff_take;
    logic [CNT_W-1:0] w_enq_add;
    logic [PTR_W-1:0] w_rd_plus1;
    logic [PTR_W-1:0] w_wr_plus1;
    logic             w_valid1;
    logic             w_valid2;

    // Free space is judged on the pre-take count, so a same-cycle take never
    // unblocks fetch until the following cycle.
    assign w_free     = DEPTH_C - r_count;
    assign w_enq      = !bus.redirect_valid && !bus.fetch_stall &&
                        (w_free >= CNT_W'(2));

    // A take of 3 behaves as 2; anything beyond the occupancy is clipped.
    assign w_take_cap = (bus.issue_take == 2'd3) ? 2'd2 : bus.issue_take;
    assign w_take_ext = CNT_W'(w_take_cap);
    assign w_eff_take = (w_take_ext > r_count) ? r_count : w_take_ext;
    assign w_enq_add  = w_enq ? CNT_W'(2) : '0;

    // Pointers are exactly PTR_W bits wide, so increments wrap modulo DEPTH.
    assign w_rd_plus1 = r_rd + PTR_W'(1);
    assign w_wr_plus1 = r_wr + PTR_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_pc    <= RESET_PC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (bus.redirect_valid) begin
            // Redirect wins over take and enqueue; the target is word aligned.
            r_pc    <= bus.redirect_pc & ~64'h3;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= r_rd + w_eff_take[PTR_W-1:0];
            r_count <= r_count + w_enq_add - w_eff_take;
            if (w_enq) begin
                r_wr <= r_wr + PTR_W'(2);
                r_pc <= r_pc + 64'd8;
            end
        end
    end

    // NOTE: the entry array has no reset; its contents only become visible
    // through count, which is reset, so stale data is never presented.
    always_ff @(posedge CLOCK) begin
        if (w_enq) begin
            r_instr_mem[r_wr]       <= bus.IC1;
            r_pc_mem[r_wr]          <= r_pc;
            r_instr_mem[w_wr_plus1] <= bus.IC2;
            r_pc_mem[w_wr_plus1]    <= r_pc + 64'd4;
        end
    end

    // Issue slots read straight from the queue head; invalid slots read 0.
    assign w_valid1 = (r_count >= CNT_W'(1));
    assign w_valid2 = (r_count >= CNT_W'(2));

    assign bus.PC1          = r_pc;
    assign bus.count        = r_count;
    assign bus.issue_valid1 = w_valid1;
    assign bus.issue_valid2 = w_valid2;
    assign bus.issue_instr1 = w_valid1 ? r_instr_mem[r_rd]      : 32'd0;
    assign bus.issue_pc1    = w_valid1 ? r_pc_mem[r_rd]         : 64'd0;
    assign bus.issue_instr2 = w_valid2 ? r_instr_mem[w_rd_plus1] : 32'd0;
    assign bus.issue_pc2    = w_valid2 ? r_pc_mem[w_rd_plus1]    : 64'd0;

endmodule

// File: tb/tb_dual_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_dual_fetch_queue
//
// Self-checking bench for dual_fetch_queue. The instruction cache returns
// instr = address. A queue-based model tracks the expected fetch PC and
// buffered entries; a compare process checks every DUT output against it on
// each falling edge, while directed sequences pin the model with literals.
// -----------------------------------------------------------------------------
module tb_dual_fetch_queue;
    localparam int          DEPTH    = 8;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    dual_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    dual_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    // Instruction cache: each instruction word equals its own address.
    assign bus.IC1 = bus.PC1[31:0];
    assign bus.IC2 = bus.PC1[31:0] + 32'd4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [95:0] mq[$];       // {instr, pc}, oldest at index 0
    logic [63:0] m_pc;
    int          m_size;
    int          m_take;
    bit          m_enq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc = RESET_PC;
        end else if (bus.redirect_valid) begin
            mq.delete();
            m_pc = bus.redirect_pc & ~64'h3;
        end else begin
            m_size = mq.size();
            m_take = (bus.issue_take == 2'd3) ? 2 : int'(bus.issue_take);
            if (m_take > m_size) m_take = m_size;
            m_enq = !bus.fetch_stall && (DEPTH - m_size >= 2);
            repeat (m_take) void'(mq.pop_front());
            if (m_enq) begin
                mq.push_back({m_pc[31:0], m_pc});
                mq.push_back({m_pc[31:0] + 32'd4, m_pc + 64'd4});
                m_pc = m_pc + 64'd8;
            end
        end
    end

    // -------------------------------------------------------------- compare
    logic [95:0] c_e1;
    logic [95:0] c_e2;
    int          c_size;

    always @(negedge clk) begin
        if (rst_n) begin
            c_size = mq.size();
            c_e1 = (c_size >= 1) ? mq[0] : 96'd0;
            c_e2 = (c_size >= 2) ? mq[1] : 96'd0;
            check("m_fetch_pc", bus.PC1, m_pc);
            check("m_count", 64'(bus.count), 64'(c_size));
            check("m_valid1", 64'(bus.issue_valid1), 64'(c_size >= 1));
            check("m_valid2", 64'(bus.issue_valid2), 64'(c_size >= 2));
            check("m_instr1", 64'(bus.issue_instr1), 64'(c_e1[95:64]));
            check("m_pc1", bus.issue_pc1, c_e1[63:0]);
            check("m_instr2", 64'(bus.issue_instr2), 64'(c_e2[95:64]));
            check("m_pc2", bus.issue_pc2, c_e2[63:0]);
        end
    end

    // ------------------------------------------------------------- stimulus
    logic [63:0] exp_pc;
    int          consumed;
    int          t;
    int          eff;

    initial begin
        rst_n              = 1'b0;
        bus.fetch_stall    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.issue_take     = 2'd0;

        repeat (2) @(negedge clk);
        check("rst_fetch_pc", bus.PC1, 64'h0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_valid1", 64'(bus.issue_valid1), 64'd0);
        check("rst_valid2", 64'(bus.issue_valid2), 64'd0);

        // Steady state: take 2 every cycle from reset release.
        bus.issue_take = 2'd2;
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("ss_count", 64'(bus.count), 64'd2);
            check("ss_pc1", bus.issue_pc1, 64'(8 * (i - 1)));
            check("ss_pc2", bus.issue_pc2, 64'(8 * (i - 1) + 4));
            check("ss_fetch_pc", bus.PC1, 64'(8 * i));
        end

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        check("arst_fetch_pc", bus.PC1, 64'h0);
        check("arst_count", 64'(bus.count), 64'd0);
        check("arst_valid1", 64'(bus.issue_valid1), 64'd0);
        check("arst_valid2", 64'(bus.issue_valid2), 64'd0);
        check("arst_pc1", bus.issue_pc1, 64'd0);
        check("arst_instr1", 64'(bus.issue_instr1), 64'd0);

        // Fill with no take.
        bus.issue_take = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("fill_count", 64'(bus.count), 64'd8);
        check("fill_fetch_pc", bus.PC1, 64'h20);
        check("fill_instr1", 64'(bus.issue_instr1), 64'h0);
        check("fill_pc1", bus.issue_pc1, 64'h0);
        check("fill_instr2", 64'(bus.issue_instr2), 64'h4);
        check("fill_pc2", bus.issue_pc2, 64'h4);
        repeat (2) @(negedge clk);
        check("full_hold_pc", bus.PC1, 64'h20);
        check("full_hold_count", 64'(bus.count), 64'd8);

        // Redirect from full with a same-cycle take.
        bus.issue_take     = 2'd2;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h1003;
        @(negedge clk);
        check("redir_count", 64'(bus.count), 64'd0);
        check("redir_valid1", 64'(bus.issue_valid1), 64'd0);
        check("redir_fetch_pc", bus.PC1, 64'h1000);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.issue_take     = 2'd0;
        @(negedge clk);
        check("redir_pc1", bus.issue_pc1, 64'h1000);
        check("redir_pc2", bus.issue_pc2, 64'h1004);
        check("redir_count2", 64'(bus.count), 64'd2);

        // Over-take under stall.
        bus.issue_take  = 2'd1;
        bus.fetch_stall = 1'b1;
        @(negedge clk);
        check("stall_count1", 64'(bus.count), 64'd1);
        check("stall_fetch_pc", bus.PC1, 64'h1008);
        check("stall_pc1", bus.issue_pc1, 64'h1004);
        bus.issue_take = 2'd3;
        @(negedge clk);
        check("overtake_count", 64'(bus.count), 64'd0);
        check("overtake_fetch_pc", bus.PC1, 64'h1008);
        check("overtake_valid1", 64'(bus.issue_valid1), 64'd0);

        // Full boundary: count 7 blocks fetch, a same-cycle take does not help.
        bus.fetch_stall = 1'b0;
        bus.issue_take  = 2'd0;
        repeat (4) @(negedge clk);
        check("bnd_fill_count", 64'(bus.count), 64'd8);
        check("bnd_fill_pc", bus.PC1, 64'h1028);
        bus.issue_take = 2'd1;
        @(negedge clk);
        check("bnd_count7", 64'(bus.count), 64'd7);
        bus.issue_take = 2'd0;
        @(negedge clk);
        check("bnd_hold_count", 64'(bus.count), 64'd7);
        check("bnd_hold_pc", bus.PC1, 64'h1028);
        bus.issue_take = 2'd3;
        @(negedge clk);
        check("bnd_take3_count", 64'(bus.count), 64'd5);
        check("bnd_take3_pc", bus.PC1, 64'h1028);
        bus.issue_take = 2'd0;
        @(negedge clk);
        check("bnd_refill_count", 64'(bus.count), 64'd7);
        check("bnd_refill_pc", bus.PC1, 64'h1030);

        // Wrap-around with take pattern 1, 2, 0 from a redirect to 0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check("wrap_start_count", 64'(bus.count), 64'd0);
        check("wrap_start_pc", bus.PC1, 64'h0);
        exp_pc   = 64'h0;
        consumed = 0;
        for (int i = 0; i < 40; i++) begin
            t   = (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 2 : 0);
            eff = (t > int'(bus.count)) ? int'(bus.count) : t;
            if (eff >= 1) begin
                check("wrap_stream_pc1", bus.issue_pc1, exp_pc);
                exp_pc   = exp_pc + 64'd4;
                consumed = consumed + 1;
            end
            if (eff == 2) begin
                check("wrap_stream_pc2", bus.issue_pc2, exp_pc);
                exp_pc   = exp_pc + 64'd4;
                consumed = consumed + 1;
            end
            check("wrap_count_le_depth", 64'(bus.count <= 8), 64'd1);
            bus.issue_take = 2'(t);
            @(negedge clk);
        end
        check("wrap_consumed_enough", 64'(consumed >= 32), 64'd1);
        bus.issue_take = 2'd0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dual_fetch_queue.md
# dual_fetch_queue

Fetch stage and instruction buffer of the dual-issue LEGv8 core, sitting between the instruction cache and decode. It generates the fetch PC and enqueues the two instructions the cache returns per cycle. It presents the two oldest instructions with their PCs to decode over a count-based handshake. Decode redirects from branch resolution flush the queue and restart fetch.

## Interface
- DEPTH, 8: queue entries; power of two, ≥4.
- RESET_PC, 64'h0: fetch address after reset.

- CLOCK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- PC1  out  64  fetch address to instruction cache; the cache returns IC1 = mem[PC1], IC2 = mem[PC1+4] combinationally in the same cycle.
- IC1  in  32  instruction at PC1.
- IC2  in  32  instruction at PC1+4.
- fetch_stall  in  1  suppresses enqueue and PC advance; no flush.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  64  new fetch address; bits [1:0] ignored and forced to 0.
- issue_valid1  out  1  slot 1 (oldest entry) valid.
- issue_valid2  out  1  slot 2 (second oldest) valid.
- issue_instr1, issue_instr2  out  32 each  slot instructions.
- issue_pc1, issue_pc2  out  64 each  slot PCs.
- issue_take  in  2  entries decode consumes this cycle: 0, 1 or 2; 3 is treated as 2.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: DEPTH entries of {instr[31:0], pc[63:0]}; read pointer rd, write pointer wr, both modulo DEPTH; count register.
- Enqueue condition: enq = !redirect_valid && !fetch_stall && (DEPTH − count ≥ 2). Free space is computed from the current count, before this cycle's take.
- On enq:
  - entry[wr] ← {IC1, PC1}.
  - entry[wr+1] ← {IC2, PC1+4}.
  - wr ← wr+2.
  - PC1 ← PC1+8.
- When enq is not asserted and redirect_valid is low, PC1 holds.
- Dequeue: eff_take = min(issue_take capped at 2, count). rd ← rd + eff_take. Take beyond count is silently clipped.
- Count update: count ← count + 2·enq − eff_take. Simultaneous enqueue and dequeue are both applied in the same cycle.
- Issue outputs (combinational from the queue head):
  - issue_valid1 = (count ≥ 1); slot 1 = entry[rd].
  - issue_valid2 = (count ≥ 2); slot 2 = entry[rd+1].
  - Instr/pc of any invalid slot read as 0.
- Redirect has priority over everything:
  - rd, wr and count ← 0.
  - PC1 ← {redirect_pc[63:2], 2'b00}.
  - Same-cycle issue_take and IC data are discarded.
- Ordering: entries leave in program order across pointer wrap-around.
- PC arithmetic: 64-bit modulo 2^64; wrap past all-ones is not flagged.

## Timing
- Reset (RESET low, asynchronous) values:
  - PC1 = RESET_PC; rd = wr = 0; count = 0.
  - issue_valid1/2 = 0.
  - issue_instr1/2 and issue_pc1/2 = 0.
  - Queue contents are don't-care.
- Reset deassertion is synchronised externally; the first enqueue occurs on the first rising edge with RESET high.
- Fetch-to-issue latency: the pair fetched at PC1 in cycle N is visible on the issue outputs in cycle N+1.
- Redirect latency: redirect in cycle N gives empty issue outputs and PC1 = target in cycle N+1. The target pair is issuable in cycle N+2.
- Full boundary: at count ≥ DEPTH−1, fetch stalls. A take in the same cycle does not unblock fetch until the next cycle.
- Empty boundary: count = 0 with enq gives count 2 next cycle; no bypass from IC to issue.
- Reset asserted mid-operation overrides redirect, stall and take immediately; in-flight entries are lost.

## Test plan
- Reset: run 5 cycles, pull RESET low between edges → PC1 = RESET_PC = 0, count = 0, issue_valid1/2 = 0 without waiting for a clock edge.
- Fill: IC model returns instr = addr, issue_take = 0 → after 4 edges count = 8, PC1 = 0x20. PC1 holds at 0x20 on further edges; slot1 = {0x0, pc 0x0}, slot2 = {0x4, pc 0x4}.
- Steady state: issue_take = 2 every cycle from reset → from cycle 1, count = 2 constant. issue_pc1 = 0, 8, 0x10, …; issue_pc2 = issue_pc1 + 4.
- Wrap and partial take: issue_take alternating 1, 2, 0 for 40 cycles → consumed PC stream strictly 0, 4, 8, … with no gaps or duplicates across multiple pointer wraps; count never exceeds 8.
- Redirect: queue full, issue_take = 2, redirect_valid = 1, redirect_pc = 0x1003 in the same cycle → next cycle count = 0, issue_valid1 = 0, PC1 = 0x1000. The following cycle has issue_pc1 = 0x1000, issue_pc2 = 0x1004.
- Over-take and stall: count = 1, issue_take = 3, fetch_stall = 1 → next cycle count = 0, PC1 unchanged, issue_valid1 = 0.
